shiftreg_piso: RTL and testbench

- Parallel-in/serial-out shift register with load handshake. It is the transmit end of the serial link.
- Captures an N-bit word, then emits it one bit per clock, LSB first, with a qualifying valid strobe and an end-of-frame pulse.
- Intended to drive the serial input of the team's serial-in/parallel-out deserializer.
- Supports back-to-back frames with no idle gap.

---
 rtl/shiftreg_piso_if.sv | 30 +++
 rtl/shiftreg_piso.sv | 86 ++++++++
 tb/tb_shiftreg_piso.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_piso_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
// master drives words in; slave is the shift register itself.
interface shiftreg_piso_if #(
  parameter int N = 8
);
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] din;
  logic         sout;
  logic         sout_valid;
  logic         done;

  modport master (
    output load_valid,
    output din,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  done
  );

  modport slave (
    input  load_valid,
    input  din,
    output load_ready,
    output sout,
    output sout_valid,
    output done
  );
endinterface

// File: rtl/shiftreg_piso.sv
// Parallel-in/serial-out transmitter, LSB first, back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module shiftreg_piso #(
  parameter int N = 8
) (
  input logic            clk,
  input logic            rst_n,
  shiftreg_piso_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = $clog2(F + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e         state_q, state_d;
  logic [F-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sout_q, sout_d;
  logic           vld_q, vld_d;
  logic           last;
  logic           ready;
  logic           accept;
  logic [F-1:0]   load_word;

  always_comb begin
    last   = (state_q == SHIFT) &&
             (cnt_q == CW'(F - 1));
    ready  = (state_q == IDLE) || last;
    accept = bus.load_valid && ready;
`ifdef PISO_PARITY_EN
    load_word = {^bus.din, bus.din};
`else
    load_word = bus.din;
`endif
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      accept: begin
        sreg_d  = load_word;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      (state_q == SHIFT) && !accept: begin
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last) state_d = IDLE;
      end
      default: ;
    endcase
    // Outputs are registered from next state so sout is glitch-free
    vld_d  = (state_d == SHIFT);
    sout_d = vld_d & sreg_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.load_ready = ready;
  assign bus.done       = last;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
endmodule

// File: tb/tb_shiftreg_piso.sv
// Randomized bench for shiftreg_piso against a bit-queue model.
// Directed frames, back-to-back, ignored loads and mid-frame reset.
module tb_shiftreg_piso;
  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   q[$];

  shiftreg_piso_if #(.N(N)) bus ();

  shiftreg_piso #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(logic [N-1:0] d);
    logic [31:0] w;
    w = 32'(d);
`ifdef PISO_PARITY_EN
    w[N] = ^d;
`endif
    return w;
  endfunction

  // Queue holds the frame bits still to be shown; head is on sout now
  task automatic model_edge();
    bit          rdy;
    bit          acc;
    logic [31:0] w;
    rdy = (q.size() <= 1);
    acc = bus.load_valid && rdy;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      w = frame_of(bus.din);
      for (int i = 0; i < F; i++) q.push_back(w[i]);
    end
  endtask

  task automatic check_outs(string tag);
    chk({tag, ":sout"}, 32'(bus.sout),
        32'(q.size() > 0 ? q[0] : 1'b0));
    chk({tag, ":valid"}, 32'(bus.sout_valid),
        32'(q.size() > 0));
    chk({tag, ":done"}, 32'(bus.done),
        32'(q.size() == 1));
    chk({tag, ":ready"}, 32'(bus.load_ready),
        32'(q.size() <= 1));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic single_frame(logic [N-1:0] d);
    logic [31:0] word;
    int          dcnt;
    word = '0;
    dcnt = 0;
    bus.din = d;
    bus.load_valid = 1'b1;
    cyc("acc");
    bus.load_valid = 1'b0;
    bus.din = '0;
    for (int k = 0; k < F; k++) begin
      word[k] = bus.sout;
      if (bus.done) dcnt++;
      if (k == F - 1) chk("single_done_last", 32'(bus.done), 1);
      if (k < F - 1) cyc("single");
    end
    chk("single_bits", word, frame_of(d));
    chk("single_done_cnt", dcnt, 1);
    cyc("single_end");
    chk("single_idle", 32'(bus.sout_valid), 0);
  endtask

  initial begin
    logic [31:0] w2;
    int          vrun;
    bus.load_valid = 1'b0;
    bus.din = '0;
    #2;
    chk("rst_sout", 32'(bus.sout), 0);
    chk("rst_valid", 32'(bus.sout_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.load_ready), 1);
    cyc("idle");

    single_frame(8'hA5);
    single_frame(8'h07);

    // back-to-back: 3C presented while A5 is still shifting
    bus.din = 8'hA5;
    bus.load_valid = 1'b1;
    cyc("b2b_acc");
    bus.din = 8'h3C;
    vrun = int'(bus.sout_valid);
    w2 = '0;
    for (int j = 0; j < 2 * F - 1; j++) begin
      cyc("b2b");
      if (bus.sout_valid) vrun++;
      if (j >= F - 1) w2[j-(F-1)] = bus.sout;
      if (j == F - 1) bus.load_valid = 1'b0;
    end
    chk("b2b_valid_run", vrun, 2 * F);
    chk("b2b_second", w2, frame_of(8'h3C));
    cyc("b2b_end");
    chk("b2b_idle", 32'(bus.sout_valid), 0);

    // load attempt mid-frame must be ignored
    bus.din = 8'hA5;
    bus.load_valid = 1'b1;
    cyc("ign_acc");
    bus.load_valid = 1'b0;
    w2 = '0;
    w2[0] = bus.sout;
    for (int k = 1; k < F; k++) begin
      if (k == 2) begin
        bus.din = 8'hFF;
        bus.load_valid = 1'b1;
        chk("ign_ready", 32'(bus.load_ready), 0);
      end else begin
        bus.load_valid = 1'b0;
      end
      cyc("ign");
      w2[k] = bus.sout;
    end
    bus.load_valid = 1'b0;
    chk("ign_bits", w2, frame_of(8'hA5));
    cyc("ign_end");
    chk("ign_idle", 32'(bus.sout_valid), 0);

    // asynchronous reset during cycle 4 of a frame
    bus.din = 8'hA5;
    bus.load_valid = 1'b1;
    cyc("mrst_acc");
    bus.load_valid = 1'b0;
    repeat (3) cyc("mrst");
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mrst_sout", 32'(bus.sout), 0);
    chk("mrst_valid", 32'(bus.sout_valid), 0);
    chk("mrst_done", 32'(bus.done), 0);
    cyc("mrst_hold");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 32'(bus.load_ready), 1);
    repeat (F + 2) cyc("mrst_after");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.din = N'($urandom);
      cyc("rand");
    end
    bus.load_valid = 1'b0;
    repeat (F + 2) cyc("drain");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
